// File: rtl/mem1p_dxw_be_clr_pkg.sv
// Shared types and helpers for the single-port masked RAM with clear sequencer.
package mem1p_dxw_be_clr_pkg;

  // Sequencer states: either serving the user port or sweeping the array to zero.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } st_e;

  // Default write-mask lane width in bits.
  localparam int DEF_LANE = 8;

  // Address width for a given depth, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem1p_dxw_be_clr_if.sv
// User-side access port of the RAM: request fields, read data and status.
interface mem1p_dxw_be_clr_if #(
  parameter int AW    = 11,
  parameter int WIDTH = 24,
  parameter int NL    = 3
) ();

  logic             clr;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [NL-1:0]    wmask;
  logic             me;
  logic             wnr;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;

  // Requester side.
  modport master (
    output clr, addr, din, wmask, me, wnr,
    input  dout, dout_vld, busy
  );

  // Memory side.
  modport slave (
    input  clr, addr, din, wmask, me, wnr,
    output dout, dout_vld, busy
  );

endinterface

// File: rtl/mem1p_dxw_be_clr_core.sv
// Raw DEPTH x WIDTH storage array with per-lane write enables and a registered,
// read-first read port.
module mem1p_core_dxw #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 24,
  parameter int LANE  = 8,
  parameter int A     = 11
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WIDTH/LANE-1:0] we,
  input  logic [A-1:0]          addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int NL = WIDTH / LANE;

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Registered read plus lane-wise write into the addressed word.
  // NOTE: the array has no reset so it maps onto block RAM; only the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (en) begin
      // NOTE: non-blocking assignments make the read return the word as it was before this edge's write.
      rdata <= mem[addr];
      for (int i = 0; i < NL; i++) begin
        if (we[i]) mem[addr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
      end
    end
  end

endmodule

// File: rtl/mem1p_dxw_be_clr.sv
// Single-port synchronous RAM with per-lane write mask, optional output register,
// selectable read-during-write result and a hardware clear sequencer.
module mem1p_dxw_be_clr
  import mem1p_dxw_be_clr_pkg::*;
#(
  parameter int DEPTH    = 2048,
  parameter int WIDTH    = 24,
  parameter int LANE     = DEF_LANE,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  parameter int INIT_CLR = 1
) (
  input logic              clk,
  input logic              rst,
  mem1p_dxw_be_clr_if.slave bus
);

  localparam int NL = WIDTH / LANE;
  localparam int A  = clog2_min1(DEPTH);
  localparam logic [A-1:0] CNT_LAST = A'(DEPTH - 1);

  st_e              state_q;
  st_e              state_d;
  logic [A-1:0]     cnt_q;
  logic             cnt_last;
  logic             busy;

  logic             in_range;
  logic             user_acc;
  logic             s1_vld_d;
  logic             core_en;
  logic [NL-1:0]    core_we;
  logic [A-1:0]     core_addr;
  logic [WIDTH-1:0] core_wdata;
  logic [WIDTH-1:0] core_rdata;

  logic             s1_vld;
  logic             s1_wr;
  logic             s1_oor;
  logic [WIDTH-1:0] s1_din;
  logic [NL-1:0]    s1_mask;
  logic [WIDTH-1:0] s1_word;

  logic             out_vld;
  logic [WIDTH-1:0] out_word;
  logic [WIDTH-1:0] dout_q;
  logic             dout_vld_q;

  assign cnt_last = (cnt_q == CNT_LAST);

  // State register: after reset either sweep the array or go straight to serving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (INIT_CLR != 0) state_q <= ST_CLEAR;
      else               state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clr starts a sweep from IDLE; the sweep ends after the last word.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.clr)  state_d = ST_CLEAR;
      ST_CLEAR: if (cnt_last) state_d = ST_IDLE;
    endcase
  end

  // State outputs: busy marks the sweep.
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  // Clear counter walks 0..DEPTH-1 once per sweep and parks at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_last ? '0 : cnt_q + A'(1);
    end
  end

  // Access mux: the sweep owns the array while busy, otherwise the user port does.
  always_comb begin
    in_range   = (32'(bus.addr) < 32'(DEPTH));
    user_acc   = bus.me & ~busy;
    s1_vld_d   = user_acc & (~bus.wnr | (RDW_MODE != 0));
    core_en    = 1'b0;
    core_we    = '0;
    core_addr  = bus.addr;
    core_wdata = bus.din;
    if (busy) begin
      core_en    = 1'b1;
      core_we    = '1;
      core_addr  = cnt_q;
      core_wdata = '0;
    end else if (user_acc && in_range) begin
      core_en = 1'b1;
      core_we = bus.wnr ? bus.wmask : '0;
    end
  end

  mem1p_core_dxw #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .LANE  (LANE),
    .A     (A)
  ) u_core (
    .clk   (clk),
    .en    (core_en),
    .we    (core_we),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Stage 1 tracks what the array read port is returning this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_wr   <= 1'b0;
      s1_oor  <= 1'b0;
      s1_din  <= '0;
      s1_mask <= '0;
    end else begin
      s1_vld  <= s1_vld_d;
      s1_wr   <= bus.wnr;
      s1_oor  <= ~in_range;
      s1_din  <= bus.din;
      s1_mask <= bus.wmask;
    end
  end

  // Result word: plain read data, or the written lanes merged over the old word.
  always_comb begin
    s1_word = core_rdata;
    if (s1_oor) begin
      s1_word = '0;
    end else if (s1_wr) begin
      for (int i = 0; i < NL; i++) begin
        if (s1_mask[i]) s1_word[i*LANE +: LANE] = s1_din[i*LANE +: LANE];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic             s2_vld;
      logic [WIDTH-1:0] s2_word;

      // Optional extra pipeline stage between the array and dout.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld  <= 1'b0;
          s2_word <= '0;
        end else begin
          s2_vld  <= s1_vld;
          s2_word <= s1_word;
        end
      end

      assign out_vld  = s2_vld;
      assign out_word = s2_word;
    end else begin : g_noreg
      assign out_vld  = s1_vld;
      assign out_word = s1_word;
    end
  endgenerate

  // Output registers: dout holds between results, dout_vld pulses per new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= out_vld;
      if (out_vld) dout_q <= out_word;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_mem1p_dxw_be_clr.sv
// Directed bench: two instances (2048 words, latency 1, write-through, auto clear;
// 1000 words, latency 2, write leaves dout alone, clear on request) driven in lockstep.
module tb_mem1p_dxw_be_clr;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  mem1p_dxw_be_clr_if #(.AW(11), .WIDTH(24), .NL(3)) bus_a ();
  mem1p_dxw_be_clr_if #(.AW(10), .WIDTH(24), .NL(3)) bus_b ();

  mem1p_dxw_be_clr #(
    .DEPTH(2048), .WIDTH(24), .LANE(8), .OUT_REG(0), .RDW_MODE(1), .INIT_CLR(1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem1p_dxw_be_clr #(
    .DEPTH(1000), .WIDTH(24), .LANE(8), .OUT_REG(1), .RDW_MODE(0), .INIT_CLR(0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        me;
    logic        wnr;
    logic [10:0] addr;
    logic [23:0] din;
    logic [2:0]  wm;
    logic        va;
    logic [23:0] da;
    logic        vb;
    logic [23:0] db;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic me, input logic wnr, input logic [10:0] addr,
                       input logic [23:0] din, input logic [2:0] wm);
    bus_a.clr   = clr;
    bus_a.me    = me;
    bus_a.wnr   = wnr;
    bus_a.addr  = addr;
    bus_a.din   = din;
    bus_a.wmask = wm;
    bus_b.clr   = clr;
    bus_b.me    = me;
    bus_b.wnr   = wnr;
    bus_b.addr  = addr[9:0];
    bus_b.din   = din;
    bus_b.wmask = wm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int a_fall;
    int b_rise;
    int b_fall;
    int bad_a;
    int bad_b;
    int n;

    // Each row: inputs sampled at one edge, outputs expected just after that edge.
    vecs[0]  = '{1'b1, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b0, 24'h000000, 1'b0, 24'h000000};
    vecs[1]  = '{1'b1, 1'b0, 11'd2047, 24'h000000, 3'b000, 1'b1, 24'h000000, 1'b0, 24'h000000};
    vecs[2]  = '{1'b0, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b1, 24'h000000, 1'b1, 24'h000000};
    vecs[3]  = '{1'b0, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b0, 24'h000000, 1'b1, 24'h000000};
    vecs[4]  = '{1'b1, 1'b1, 11'd5,    24'hABCDEF, 3'b111, 1'b0, 24'h000000, 1'b0, 24'h000000};
    vecs[5]  = '{1'b1, 1'b1, 11'd5,    24'h112233, 3'b010, 1'b1, 24'hABCDEF, 1'b0, 24'h000000};
    vecs[6]  = '{1'b1, 1'b0, 11'd5,    24'h000000, 3'b000, 1'b1, 24'hAB22EF, 1'b0, 24'h000000};
    vecs[7]  = '{1'b0, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b1, 24'hAB22EF, 1'b0, 24'h000000};
    vecs[8]  = '{1'b1, 1'b1, 11'd9,    24'hFFFFFF, 3'b001, 1'b0, 24'hAB22EF, 1'b1, 24'hAB22EF};
    vecs[9]  = '{1'b0, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b1, 24'h0000FF, 1'b0, 24'hAB22EF};
    vecs[10] = '{1'b1, 1'b0, 11'd9,    24'h000000, 3'b000, 1'b0, 24'h0000FF, 1'b0, 24'hAB22EF};
    vecs[11] = '{1'b1, 1'b1, 11'd999,  24'h654321, 3'b111, 1'b1, 24'h0000FF, 1'b0, 24'hAB22EF};
    vecs[12] = '{1'b1, 1'b1, 11'd1000, 24'h123456, 3'b111, 1'b1, 24'h654321, 1'b1, 24'h0000FF};
    vecs[13] = '{1'b1, 1'b0, 11'd1000, 24'h000000, 3'b000, 1'b1, 24'h123456, 1'b0, 24'h0000FF};
    vecs[14] = '{1'b1, 1'b0, 11'd999,  24'h000000, 3'b000, 1'b1, 24'h123456, 1'b0, 24'h0000FF};
    vecs[15] = '{1'b1, 1'b1, 11'd5,    24'hFFFFFF, 3'b000, 1'b1, 24'h654321, 1'b1, 24'h000000};
    vecs[16] = '{1'b1, 1'b0, 11'd5,    24'h000000, 3'b000, 1'b1, 24'hAB22EF, 1'b1, 24'h654321};
    vecs[17] = '{1'b0, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b1, 24'hAB22EF, 1'b0, 24'h654321};
    vecs[18] = '{1'b0, 1'b0, 11'd0,    24'h000000, 3'b000, 1'b0, 24'hAB22EF, 1'b1, 24'hAB22EF};

    // Reset state.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
    #3;
    check("reset a_dout", bus_a.dout, 24'h0);
    check("reset a_vld", bus_a.dout_vld, 1'b0);
    check("reset a_busy", bus_a.busy, 1'b1);
    check("reset b_busy", bus_b.busy, 1'b0);
    check("reset b_vld", bus_b.dout_vld, 1'b0);
    repeat (2) @(posedge clk);

    // Release reset; request a clear on both (the auto-clearing instance must ignore it).
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
    #1;
    check("init a_busy high", bus_a.busy, 1'b1);
    e = 0;
    a_fall = -1;
    b_rise = -1;
    b_fall = -1;
    while (e < 3000 && (a_fall < 0 || b_fall < 0)) begin
      step();
      e++;
      if (e == 1) drive(1'b0, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
      if (b_rise < 0 && bus_b.busy) b_rise = e;
      if (b_rise >= 0 && b_fall < 0 && !bus_b.busy) b_fall = e;
      if (a_fall < 0 && !bus_a.busy) a_fall = e;
    end
    check("init a_busy cycles", a_fall, 2048);
    check("clr b_busy start", b_rise, 1);
    check("clr b_busy cycles", b_fall - b_rise, 1000);

    // Table-driven directed vectors.
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, vecs[i].me, vecs[i].wnr, vecs[i].addr, vecs[i].din, vecs[i].wm);
      step();
      check($sformatf("vec%0d a_vld", i), bus_a.dout_vld, vecs[i].va);
      check($sformatf("vec%0d a_dout", i), bus_a.dout, vecs[i].da);
      check($sformatf("vec%0d b_vld", i), bus_b.dout_vld, vecs[i].vb);
      check($sformatf("vec%0d b_dout", i), bus_b.dout, vecs[i].db);
    end

    // clr in IDLE with a read in the same cycle, then reads while clearing.
    drive(1'b1, 1'b1, 1'b0, 11'd5, 24'h0, 3'b000);
    step();
    check("clr a_busy", bus_a.busy, 1'b1);
    check("clr b_busy", bus_b.busy, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 11'd5, 24'h0, 3'b000);
    bad_a = 0;
    bad_b = 0;
    a_fall = -1;
    b_fall = -1;
    e = 0;
    while (e < 2200 && (bus_a.busy || bus_b.busy)) begin
      step();
      e++;
      if (e == 1) begin
        check("clr same-cycle a_vld", bus_a.dout_vld, 1'b1);
        check("clr same-cycle a_dout", bus_a.dout, 24'hAB22EF);
      end
      if (e == 2) begin
        check("clr same-cycle b_vld", bus_b.dout_vld, 1'b1);
        check("clr same-cycle b_dout", bus_b.dout, 24'hAB22EF);
      end
      if (e == 200) drive(1'b0, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
      if (e >= 2 && bus_a.dout_vld) bad_a++;
      if (e >= 3 && bus_b.dout_vld) bad_b++;
      if (a_fall < 0 && !bus_a.busy) a_fall = e;
      if (b_fall < 0 && !bus_b.busy) b_fall = e;
    end
    check("busy reads a_vld pulses", bad_a, 0);
    check("busy reads b_vld pulses", bad_b, 0);
    check("clr a_busy cycles", a_fall, 2048);
    check("clr b_busy cycles", b_fall, 1000);

    // Previously written addr 5 reads back zero after the sweep.
    drive(1'b0, 1'b1, 1'b0, 11'd5, 24'h0, 3'b000);
    step();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
    step();
    check("post-clr a_vld", bus_a.dout_vld, 1'b1);
    check("post-clr a_dout", bus_a.dout, 24'h0);
    step();
    check("post-clr b_vld", bus_b.dout_vld, 1'b1);
    check("post-clr b_dout", bus_b.dout, 24'h0);

    // Make dout non-zero, then reset mid-cycle: outputs clear immediately.
    drive(1'b0, 1'b1, 1'b1, 11'd2047, 24'h777777, 3'b111);
    step();
    drive(1'b0, 1'b1, 1'b1, 11'd3, 24'h5A5A5A, 3'b111);
    step();
    drive(1'b0, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
    step();
    check("pre-rst a_dout", bus_a.dout, 24'h5A5A5A);
    #2;
    rst = 1'b1;
    #1;
    check("async rst a_dout", bus_a.dout, 24'h0);
    check("async rst a_vld", bus_a.dout_vld, 1'b0);
    check("async rst a_busy", bus_a.busy, 1'b1);
    check("async rst b_busy", bus_b.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Interrupt the auto clear at cnt=300; it must restart and run a full sweep.
    repeat (300) step();
    check("cnt300 a_busy", bus_a.busy, 1'b1);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (bus_a.busy && n < 3000) begin
      step();
      n++;
    end
    check("restart a_busy cycles", n, 2048);
    drive(1'b0, 1'b1, 1'b0, 11'd2047, 24'h0, 3'b000);
    step();
    drive(1'b0, 1'b1, 1'b0, 11'd3, 24'h0, 3'b000);
    step();
    check("restart rd2047 a_vld", bus_a.dout_vld, 1'b1);
    check("restart rd2047 a_dout", bus_a.dout, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 11'd0, 24'h0, 3'b000);
    step();
    check("restart rd3 a_vld", bus_a.dout_vld, 1'b1);
    check("restart rd3 a_dout", bus_a.dout, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
